fir_tap_sequencer: RTL and testbench

//  Upstream feeder for the checksum (sample x coefficient) multiplier stage.
//  - Accepts one input sample per handshake and keeps a TAPS-deep delay line.
//  - Holds a writable coefficient table.
//  - For each new sample, issues the TAPS (delayed-sample, coefficient) pairs serially,
//    one pair per issue slot, on the multiplier's in_data/polynomial interface.
//  - Marks the first and last tap so the downstream accumulator can frame each FIR output.

---
 rtl/fir_tap_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: keeps a TAPS-deep sample delay line and a writable
// coefficient table, and for every accepted sample issues the TAPS
// (delayed sample, coefficient) pairs serially to the multiplier stage,
// framing each FIR output with first/last markers.
module fir_tap_sequencer #(
  parameter int DATA_WIDTH = 17,
  parameter int COEF_WIDTH = 4,
  parameter int TAPS       = 8,
  parameter int IDX_WIDTH  = 3,
  parameter int ISSUE_GAP  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  smp_vld,
  input  logic [DATA_WIDTH-1:0] smp_data,
  output logic                  smp_rdy,
  input  logic                  coef_wr,
  input  logic [IDX_WIDTH-1:0]  coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  output logic                  mul_vld,
  output logic [DATA_WIDTH-1:0] mul_data,
  output logic [COEF_WIDTH-1:0] mul_coef,
  output logic                  mul_first,
  output logic                  mul_last
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(TAPS - 1);
  localparam logic [3:0]           GAP_LOAD = (ISSUE_GAP > 0) ? 4'(ISSUE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [3:0]            gap_q, gap_d;
  logic [DATA_WIDTH-1:0] dl_q   [TAPS];
  logic [DATA_WIDTH-1:0] dl_d   [TAPS];
  logic [COEF_WIDTH-1:0] coef_q [TAPS];
  logic [COEF_WIDTH-1:0] coef_d [TAPS];
  logic                  smp_rdy_q, smp_rdy_d;
  logic                  mul_vld_q, mul_vld_d;
  logic [DATA_WIDTH-1:0] mul_data_q, mul_data_d;
  logic [COEF_WIDTH-1:0] mul_coef_q, mul_coef_d;
  logic                  mul_first_q, mul_first_d;
  logic                  mul_last_q, mul_last_d;
  logic                  accept;

  // smp_rdy_q is high exactly when the FSM sits in IDLE.
  assign accept = smp_vld & smp_rdy_q;

  // Next-state logic: state_q/idx_q describe the pair currently on the outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else if (ISSUE_GAP == 0) begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end else begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ISSUE;
          idx_d   = idx_q + IDX_WIDTH'(1);
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Delay-line shift on accept and coefficient table writes (out-of-range index ignored).
  always_comb begin
    dl_d   = dl_q;
    coef_d = coef_q;
    if (accept) begin
      dl_d[0] = smp_data;
      for (int k = 1; k < TAPS; k++) begin
        dl_d[k] = dl_q[k-1];
      end
    end
    if (coef_wr && (int'(coef_addr) < TAPS)) begin
      coef_d[coef_addr] = coef_data;
    end
  end

  // Output register inputs: the data path reads the post-shift delay line so a
  // sample accepted at this edge is tap 0, while the coefficient path reads the
  // pre-write table so a same-edge write to the issued index is not yet visible.
  always_comb begin
    mul_vld_d   = (state_d == ISSUE);
    mul_data_d  = mul_data_q;
    mul_coef_d  = mul_coef_q;
    mul_first_d = 1'b0;
    mul_last_d  = 1'b0;
    smp_rdy_d   = (state_d == IDLE);
    if (mul_vld_d) begin
      mul_data_d  = dl_d[idx_d];
      mul_coef_d  = coef_q[idx_d];
      mul_first_d = (idx_d == '0);
      mul_last_d  = (idx_d == LAST_IDX);
    end
  end

  // State, storage and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      gap_q       <= 4'd0;
      // NOTE: the delay line and coefficient table are cleared on reset because
      // unwritten entries must read as zero; this costs a reset on every storage flop.
      dl_q        <= '{default: '0};
      coef_q      <= '{default: '0};
      smp_rdy_q   <= 1'b1;
      mul_vld_q   <= 1'b0;
      mul_data_q  <= '0;
      mul_coef_q  <= '0;
      mul_first_q <= 1'b0;
      mul_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      dl_q        <= dl_d;
      coef_q      <= coef_d;
      smp_rdy_q   <= smp_rdy_d;
      mul_vld_q   <= mul_vld_d;
      mul_data_q  <= mul_data_d;
      mul_coef_q  <= mul_coef_d;
      mul_first_q <= mul_first_d;
      mul_last_q  <= mul_last_d;
    end
  end

  assign smp_rdy   = smp_rdy_q;
  assign mul_vld   = mul_vld_q;
  assign mul_data  = mul_data_q;
  assign mul_coef  = mul_coef_q;
  assign mul_first = mul_first_q;
  assign mul_last  = mul_last_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Testbench for fir_tap_sequencer: a table of per-cycle vectors for the basic
// sequences, plus hand-written sequences for back-pressure, issue gaps,
// coefficient write timing, out-of-range writes and mid-sequence reset.
module tb_fir_tap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        smp_vld;
  logic [16:0] smp_data;
  logic        coef_wr;
  logic [2:0]  coef_addr;
  logic [3:0]  coef_data;

  logic d_rdy, d_vld, d_first, d_last;
  logic [16:0] d_data;
  logic [3:0]  d_coef;
  logic g_rdy, g_vld, g_first, g_last;
  logic [16:0] g_data;
  logic [3:0]  g_coef;
  logic s_rdy, s_vld, s_first, s_last;
  logic [16:0] s_data;
  logic [3:0]  s_coef;

  logic [24:0] d_out, g_out, s_out;
  assign d_out = {d_vld, d_first, d_last, d_rdy, d_data, d_coef};
  assign g_out = {g_vld, g_first, g_last, g_rdy, g_data, g_coef};
  assign s_out = {s_vld, s_first, s_last, s_rdy, s_data, s_coef};

  always #5 clk = ~clk;

  // Default configuration.
  fir_tap_sequencer u_dut (
    .clk(clk), .reset(reset), .smp_vld(smp_vld), .smp_data(smp_data), .smp_rdy(d_rdy),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .mul_vld(d_vld), .mul_data(d_data), .mul_coef(d_coef), .mul_first(d_first), .mul_last(d_last)
  );

  // Two idle cycles between taps.
  fir_tap_sequencer #(.ISSUE_GAP(2)) u_gap (
    .clk(clk), .reset(reset), .smp_vld(smp_vld), .smp_data(smp_data), .smp_rdy(g_rdy),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .mul_vld(g_vld), .mul_data(g_data), .mul_coef(g_coef), .mul_first(g_first), .mul_last(g_last)
  );

  // Five taps, so indices 5..7 are out of range.
  fir_tap_sequencer #(.TAPS(5)) u_small (
    .clk(clk), .reset(reset), .smp_vld(smp_vld), .smp_data(smp_data), .smp_rdy(s_rdy),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .mul_vld(s_vld), .mul_data(s_data), .mul_coef(s_coef), .mul_first(s_first), .mul_last(s_last)
  );

  typedef struct {
    logic        sv;
    logic [16:0] sd;
    logic        cw;
    logic [2:0]  ca;
    logic [3:0]  cd;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   prod_idx = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] pk(input logic v, input logic f, input logic l, input logic r,
                                     input logic [16:0] d, input logic [3:0] c);
    return {v, f, l, r, d, c};
  endfunction

  function automatic void add_vec(input logic sv, input logic [16:0] sd, input logic cw,
                                  input logic [2:0] ca, input logic [3:0] cd, input logic [24:0] e);
    vec_t v;
    v.sv = sv; v.sd = sd; v.cw = cw; v.ca = ca; v.cd = cd; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    smp_vld   = 1'b0;
    smp_data  = '0;
    coef_wr   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic acc;
    int   n_acc, n_first, last_acc, k, low, n_v;

    // ---- vector table: coefficient load, then three back-to-back samples ----
    for (int i = 0; i < 8; i++) add_vec(1'b0, 17'd0, 1'b1, 3'(i), 4'(i + 1), pk(0, 0, 0, 1, 17'd0, 4'd0));
    add_vec(1'b1, 17'd5, 1'b0, 3'd0, 4'd0, pk(1, 1, 0, 0, 17'd5, 4'd1));
    for (int t = 1; t < 8; t++) add_vec(1'b0, 17'd0, 1'b0, 3'd0, 4'd0, pk(1, 0, t == 7, 0, 17'd0, 4'(t + 1)));
    add_vec(1'b0, 17'd0, 1'b0, 3'd0, 4'd0, pk(0, 0, 0, 1, 17'd0, 4'd8));

    add_vec(1'b1, 17'd7, 1'b0, 3'd0, 4'd0, pk(1, 1, 0, 0, 17'd7, 4'd1));
    for (int t = 1; t < 8; t++)
      add_vec(1'b0, 17'd0, t == 3, 3'd0, 4'd15, pk(1, 0, t == 7, 0, (t == 1) ? 17'd5 : 17'd0, 4'(t + 1)));
    add_vec(1'b0, 17'd0, 1'b0, 3'd0, 4'd0, pk(0, 0, 0, 1, 17'd0, 4'd8));

    prod_idx = tbl.size();
    add_vec(1'b1, 17'd131071, 1'b0, 3'd0, 4'd0, pk(1, 1, 0, 0, 17'd131071, 4'd15));
    for (int t = 1; t < 8; t++)
      add_vec(1'b0, 17'd0, 1'b0, 3'd0, 4'd0,
              pk(1, 0, t == 7, 0, (t == 1) ? 17'd7 : (t == 2) ? 17'd5 : 17'd0, 4'(t + 1)));
    add_vec(1'b0, 17'd0, 1'b0, 3'd0, 4'd0, pk(0, 0, 0, 1, 17'd0, 4'd8));

    // ---- reset state ----
    do_reset();
    check("rst_default", 32'(d_out), 32'(pk(0, 0, 0, 1, 17'd0, 4'd0)));
    check("rst_gap",     32'(g_out), 32'(pk(0, 0, 0, 1, 17'd0, 4'd0)));
    check("rst_small",   32'(s_out), 32'(pk(0, 0, 0, 1, 17'd0, 4'd0)));

    // ---- apply the table ----
    for (int i = 0; i < tbl.size(); i++) begin
      smp_vld   = tbl[i].sv;
      smp_data  = tbl[i].sd;
      coef_wr   = tbl[i].cw;
      coef_addr = tbl[i].ca;
      coef_data = tbl[i].cd;
      tick();
      check($sformatf("vec%0d", i), 32'(d_out), 32'(tbl[i].exp));
      if (i == prod_idx) check("product", 32'(d_data) * 32'(d_coef), 32'd1966065);
    end
    smp_vld = 1'b0;
    coef_wr = 1'b0;

    // ---- smp_vld held high: accepts 9 cycles apart, no drops or duplicates ----
    smp_vld  = 1'b1;
    smp_data = 17'd1;
    n_acc    = 0;
    n_first  = 0;
    last_acc = 0;
    for (int c = 0; c < 40 && n_acc < 3; c++) begin
      acc = d_rdy;
      tick();
      if (d_vld && d_first) n_first++;
      if (acc) begin
        check($sformatf("hold_tap0_%0d", n_acc), {13'd0, d_vld, d_first, d_data},
              {13'd0, 1'b1, 1'b1, 17'(n_acc + 1)});
        if (n_acc > 0) check("hold_spacing", 32'(c - last_acc), 32'd9);
        last_acc = c;
        n_acc++;
        smp_data = 17'(n_acc + 1);
      end
    end
    smp_vld = 1'b0;
    check("hold_accepts", 32'(n_acc), 32'd3);
    check("hold_firsts", 32'(n_first), 32'd3);
    repeat (10) tick();

    // ---- ISSUE_GAP=2: pulses every 3 cycles, rdy low for 22 cycles ----
    do_reset();
    smp_vld  = 1'b1;
    smp_data = 17'd3;
    tick();
    smp_vld = 1'b0;
    k   = 0;
    low = 0;
    for (int c = 1; c <= 30; c++) begin
      if (g_vld) begin
        check($sformatf("gap_tap%0d", k), {g_first, g_last, g_data, 13'(c)},
              {k == 0, k == 7, (k == 0) ? 17'd3 : 17'd0, 13'(1 + 3 * k)});
        k++;
      end
      if (!g_rdy) low++;
      tick();
    end
    check("gap_count", 32'(k), 32'd8);
    check("gap_rdy_low", 32'(low), 32'd22);

    // ---- coefficient write timing and out-of-range writes ----
    for (int i = 0; i < 8; i++) begin
      coef_wr   = 1'b1;
      coef_addr = 3'(i);
      coef_data = 4'(i + 1);
      tick();
    end
    coef_wr  = 1'b0;
    smp_vld  = 1'b1;
    smp_data = 17'd20;
    tick();
    smp_vld = 1'b0;
    for (int t = 0; t < 8; t++) begin
      check($sformatf("wr_tap%0d", t), 32'(d_out),
            32'(pk(1, t == 0, t == 7, 0, (t == 0) ? 17'd20 : (t == 1) ? 17'd3 : 17'd0,
                   (t == 6) ? 4'd9 : (t == 2) ? 4'd3 : 4'(t + 1))));
      if (t < 5)
        check($sformatf("small_tap%0d", t), 32'(s_out),
              32'(pk(1, t == 0, t == 4, 0, (t == 0) ? 17'd20 : (t == 1) ? 17'd3 : 17'd0,
                     (t == 2) ? 4'd3 : 4'(t + 1))));
      else if (t == 5)
        check("small_idle", 32'(s_out), 32'(pk(0, 0, 0, 1, 17'd0, 4'd5)));
      coef_wr   = (t == 1) || (t == 2);
      coef_addr = (t == 1) ? 3'd2 : 3'd6;
      coef_data = (t == 1) ? 4'd11 : 4'd9;
      tick();
    end
    coef_wr = 1'b0;
    check("wr_idle", 32'(d_out), 32'(pk(0, 0, 0, 1, 17'd0, 4'd8)));

    // ---- next sample sees coef[2]=11; reset during tap 4 aborts ----
    smp_vld  = 1'b1;
    smp_data = 17'd21;
    tick();
    smp_vld = 1'b0;
    for (int t = 0; t < 5; t++) begin
      check($sformatf("rs_tap%0d", t), 32'(d_out),
            32'(pk(1, t == 0, 0, 0,
                   (t == 0) ? 17'd21 : (t == 1) ? 17'd20 : (t == 2) ? 17'd3 : 17'd0,
                   (t == 2) ? 4'd11 : 4'(t + 1))));
      if (t < 4) tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rs_abort", 32'(d_out), 32'(pk(0, 0, 0, 1, 17'd0, 4'd0)));
    n_v = 0;
    repeat (10) begin
      tick();
      if (d_vld) n_v++;
    end
    check("rs_quiet", 32'(n_v), 32'd0);
    smp_vld  = 1'b1;
    smp_data = 17'd42;
    tick();
    smp_vld = 1'b0;
    for (int t = 0; t < 8; t++) begin
      check($sformatf("post_rst_tap%0d", t), 32'(d_out),
            32'(pk(1, t == 0, t == 7, 0, (t == 0) ? 17'd42 : 17'd0, 4'd0)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
